// File: rtl/fixed_point_accum_sub_seq_if.sv
// Operand/result handshake bundle for the burst accumulator.
// Master drives the burst; slave is the accumulator.
interface fixed_point_accum_sub_seq_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               start;
  logic [WIDTH-1:0]   init;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               overflowFlag;
  logic               busy;

  modport master (
    output start, init, len,
    output in_valid, in_data, in_op,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  overflowFlag, busy
  );

  modport slave (
    input  start, init, len,
    input  in_valid, in_data, in_op,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output overflowFlag, busy
  );
endinterface

// File: rtl/fixed_point_accum_sub_seq.sv
// Burst add/subtract accumulator with sticky overflow flag.
// Define FIXED_POINT_ACCUM_SATURATE_EN to clamp on overflow.
module fixed_point_accum_sub_seq #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input logic clk,
  input logic rst,
  fixed_point_accum_sub_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_acc;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_step;
  logic               w_ovf;
  logic               w_xfer;

  assign w_b   = bus.in_op ? ~bus.in_data : bus.in_data;
  assign w_sum = r_acc + w_b
               + {{(WIDTH-1){1'b0}}, bus.in_op};
  assign w_ovf = (r_acc[WIDTH-1] == w_b[WIDTH-1])
              && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

`ifdef FIXED_POINT_ACCUM_SATURATE_EN
  // Clamp toward the sign the accumulator had before the step
  always_comb begin
    w_step = w_sum;
    if (w_ovf) begin
      w_step = r_acc[WIDTH-1]
             ? {1'b1, {(WIDTH-1){1'b0}}}
             : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_step = w_sum;
`endif

  assign w_xfer = (r_state == ACCUM) && bus.in_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_xfer && r_count == COUNT_W'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_acc   <= bus.init;
      r_count <= bus.len;
      r_ovf   <= 1'b0;
    end else if (w_xfer) begin
      r_acc   <= w_step;
      r_count <= r_count - COUNT_W'(1);
      r_ovf   <= r_ovf | w_ovf;
    end
  end

  assign bus.in_ready     = (r_state == ACCUM);
  assign bus.out_valid    = (r_state == DONE);
  assign bus.out_data     = r_acc;
  assign bus.overflowFlag = r_ovf;
  assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_fixed_point_accum_sub_seq.sv
// Directed bench for the burst accumulator.
// Expected values are hand-computed per build flavour.
module tb_fixed_point_accum_sub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fixed_point_accum_sub_seq_if #(.WIDTH(16), .COUNT_W(8)) bus ();

  fixed_point_accum_sub_seq #(.WIDTH(16), .COUNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_burst(input logic [15:0] ini,
                             input logic [7:0] n);
    bus.start = 1'b1;
    bus.init  = ini;
    bus.len   = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d, input logic op);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.init      = '0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_ovf", 32'(bus.overflowFlag), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    step();

    // Basic add burst
    begin_burst(16'h0010, 8'd3);
    chk("t1_ready0", 32'(bus.in_ready), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b0;
    bus.in_data  = 16'h0001;
    step();
    chk("t1_ready1", 32'(bus.in_ready), 1);
    bus.in_data = 16'h0002;
    step();
    chk("t1_ready2", 32'(bus.in_ready), 1);
    bus.in_data = 16'h0003;
    step();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_in_ready_done", 32'(bus.in_ready), 0);
    chk("t1_data", 32'(bus.out_data), 32'h0016);
    chk("t1_ovf", 32'(bus.overflowFlag), 0);
    handshake();
    chk("t1_idle_valid", 32'(bus.out_valid), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_hold_data", 32'(bus.out_data), 32'h0016);

    // Mixed op with stalls
    begin_burst(16'h0100, 8'd2);
    step(); step();
    chk("t2_stall_acc", 32'(bus.out_data), 32'h0100);
    chk("t2_stall_ready", 32'(bus.in_ready), 1);
    feed(16'h0180, 1'b1);
    step(); step();
    chk("t2_mid_acc", 32'(bus.out_data), 32'hFF80);
    chk("t2_mid_valid", 32'(bus.out_valid), 0);
    feed(16'h0010, 1'b0);
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_data", 32'(bus.out_data), 32'hFF90);
    chk("t2_ovf", 32'(bus.overflowFlag), 0);
    handshake();

    // Positive overflow, sticky flag
    begin_burst(16'h7FF0, 8'd2);
    feed(16'h0020, 1'b0);
    chk("t3_ovf_first", 32'(bus.overflowFlag), 1);
    feed(16'h0001, 1'b0);
    chk("t3_valid", 32'(bus.out_valid), 1);
`ifdef FIXED_POINT_ACCUM_SATURATE_EN
    chk("t3_data", 32'(bus.out_data), 32'h7FFF);
`else
    chk("t3_data", 32'(bus.out_data), 32'h8011);
`endif
    chk("t3_ovf", 32'(bus.overflowFlag), 1);
    handshake();

    // Subtract most negative value
    begin_burst(16'h0000, 8'd1);
    feed(16'h8000, 1'b1);
    chk("t4_valid", 32'(bus.out_valid), 1);
`ifdef FIXED_POINT_ACCUM_SATURATE_EN
    chk("t4_data", 32'(bus.out_data), 32'h7FFF);
`else
    chk("t4_data", 32'(bus.out_data), 32'h8000);
`endif
    chk("t4_ovf", 32'(bus.overflowFlag), 1);
    handshake();

    // len=0 with backpressure; start during DONE ignored
    begin_burst(16'h1234, 8'd0);
    chk("t5_valid", 32'(bus.out_valid), 1);
    chk("t5_data", 32'(bus.out_data), 32'h1234);
    chk("t5_ovf_clr", 32'(bus.overflowFlag), 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin_burst(16'h5555, 8'd3);
      else step();
      chk($sformatf("t5_hold_valid%0d", i),
          32'(bus.out_valid), 1);
      chk($sformatf("t5_hold_data%0d", i),
          32'(bus.out_data), 32'h1234);
    end
    bus.start = 1'b1;
    bus.init  = 16'hBEEF;
    bus.len   = 8'd0;
    handshake();
    bus.start = 1'b0;
    chk("t5_idle_valid", 32'(bus.out_valid), 0);
    chk("t5_idle_busy", 32'(bus.busy), 0);
    chk("t5_idle_data", 32'(bus.out_data), 32'h1234);
    step();
    chk("t5_hs_start_ign", 32'(bus.busy), 0);

    // Reset mid-burst
    begin_burst(16'hAAAA, 8'd4);
    feed(16'h0001, 1'b0);
    chk("t6_busy_mid", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_ready", 32'(bus.in_ready), 0);
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_data", 32'(bus.out_data), 0);
    chk("t6_ovf", 32'(bus.overflowFlag), 0);
    step(); step();
    chk("t6_no_result", 32'(bus.out_valid), 0);
    begin_burst(16'h0001, 8'd1);
    feed(16'h0001, 1'b0);
    chk("t6_new_valid", 32'(bus.out_valid), 1);
    chk("t6_new_data", 32'(bus.out_data), 32'h0002);
    chk("t6_new_ovf", 32'(bus.overflowFlag), 0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fixed_point_accum_sub_seq.md
Name: fixed_point_accum_sub_seq

Overview:
- Sequential two's-complement accumulator. Consumes a stream of operands, each tagged add or subtract, and returns the running total of one burst.
- Sits downstream of the combinational adder/subtractor datapath in the ODE solver. It is the receiving end of the {operand, op, overflowFlag} interface.
- Accepts a start with a burst length, folds that many operands into an accumulator, then presents the result with a sticky overflow flag.

Parameters:
- WIDTH, 16: operand and accumulator width, two's complement fixed point. The binary point is irrelevant to the block.
- COUNT_W, 8: width of the burst-length field. Maximum burst is 2^COUNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; sampled only in IDLE
- init  input  WIDTH  initial accumulator value, captured with start
- len  input  COUNT_W  number of operands in the burst, captured with start
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  WIDTH  operand
- in_op  input  1  0 = add, 1 = subtract (acc - in_data)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  final accumulator
- overflowFlag  output  1  sticky: at least one step in the burst overflowed
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset is synchronous, active-high, on rising clk.
  - State goes to IDLE.
  - acc, count, out_data = 0.
  - in_ready, out_valid, overflowFlag, busy = 0.
- Reset mid-burst aborts immediately. No result is produced.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - On start: acc<=init, count<=len, overflowFlag<=0.
  - If len==0, go directly to DONE with out_data=init.
  - Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - On transfer: acc<=step(acc,in_data,in_op), count<=count-1, overflowFlag<=overflowFlag|step_ovf.
  - When a transfer occurs with count==1, go to DONE next cycle.
  - Cycles with in_valid=0 stall with no state change.
  - Throughput is one operand per cycle.
- step arithmetic:
  - b' = in_op ? ~in_data : in_data.
  - sum = acc + b' + in_op, computed modulo 2^WIDTH.
  - step_ovf = (acc[MSB]==b'[MSB]) && (sum[MSB]!=acc[MSB]). This is equivalent to carry into MSB XOR carry out of MSB.
  - Subtracting the most negative value is covered by this rule and needs no special case.
- DONE:
  - out_valid=1, out_data=acc, overflowFlag held.
  - When out_valid && out_ready, go to IDLE the next cycle. out_valid drops; out_data and overflowFlag hold their last values.
  - in_ready=0.
  - Outputs stay stable while out_ready=0.
- Latency:
  - The result is valid the cycle after the last operand transfer.
  - For len=0, it is valid the cycle after start.
- start outside IDLE is ignored.
- A start in the same cycle as the DONE handshake is ignored. Start is honoured only while the state is IDLE.
- count never wraps: the ACCUM exit occurs at 1, and the len=0 case bypasses ACCUM.
- busy = (state != IDLE).

Optional Feature:
- Macro: FIXED_POINT_ACCUM_SATURATE_EN.
- When defined, on any step with step_ovf=1, acc is loaded with the saturated value instead of the wrapped sum:
  - +max (0111…1) if acc[MSB]==0.
  - -max (1000…0) if acc[MSB]==1.
  - Subsequent steps continue from the saturated value. overflowFlag is still set and sticky.
- When not defined, acc wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- Basic add burst. Stimulus: init=0x0010, len=3, operands +0x0001, +0x0002, +0x0003, add, one per cycle. Response: in_ready high for 3 cycles; out_valid the cycle after the 3rd transfer; out_data=0x0016, overflowFlag=0.
- Mixed op with stalls. Stimulus: init=0x0100, len=2, sub 0x0180 then add 0x0010, with in_valid gaps of 2 cycles. Response: out_data=0xFF90, overflowFlag=0, no state change during gaps.
- Positive overflow. Stimulus: init=0x7FF0, len=2, add 0x0020, add 0x0001. Response:
  - Wrap build: out_data=0x8011, overflowFlag=1.
  - Saturate build: out_data=0x7FFF, overflowFlag=1.
- Negative edge. Stimulus: init=0x0000, len=1, sub 0x8000. Response:
  - Wrap build: out_data=0x8000, overflowFlag=1.
  - Saturate build: 0x7FFF.
- len=0 and backpressure. Stimulus: start with init=0x1234, len=0; hold out_ready=0 for 5 cycles. Response: out_valid and out_data=0x1234 stable throughout; a start pulse during DONE is ignored; IDLE is entered the cycle after out_ready=1.
- Reset mid-burst. Stimulus: assert rst after 1 of 4 operands. Response: next cycle IDLE, all outputs 0; a new burst with init=0x0001, len=1, add 0x0001 yields 0x0002, overflowFlag=0.
